// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache (8 x 4-byte lines by default).
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module data_cache #(
  parameter int NUM_LINES   = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 8 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    MEM_FETCH,
    UPDATE
  } state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  logic        mem_read_q;
  logic        mem_write_q;
  logic [5:0]  mem_address_q;
  logic [31:0] mem_writedata_q;
  logic [31:0] fill_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] addr_tag;
  logic [OFF_W-1:0] offset;
  logic [31:0]      line;
  logic             req;
  logic             hit;
  logic             write_hit;

  assign idx      = ADDRESS[OFF_W +: IDX_W];
  assign addr_tag = ADDRESS[7 -: TAG_W];
  assign offset   = ADDRESS[OFF_W-1:0];
  assign line     = data_q[idx];

  assign req       = READ | WRITE;
  assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign write_hit = (state_q == IDLE) && WRITE && hit;

  // Combinational stall so a hit completes in the cycle it is presented.
  assign BUSYWAIT = req && !((state_q == IDLE) && hit);
  assign READDATA = line[{offset, 3'b000} +: 8];

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_address_q;
  assign MEM_WRITEDATA = mem_writedata_q;

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:       if (req && !hit) state_d = dirty_q[idx] ? WRITE_BACK : MEM_FETCH;
      WRITE_BACK: if (!MEM_BUSYWAIT) state_d = MEM_FETCH;
      MEM_FETCH:  if (!MEM_BUSYWAIT) state_d = UPDATE;
      UPDATE:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Block FSM with registered memory-side outputs, set up on the transition into each state.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
    if (RESET) begin
      state_q         <= IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      fill_q          <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (state_d == WRITE_BACK) begin
            mem_write_q     <= 1'b1;
            mem_address_q   <= {tag_q[idx], idx};
            mem_writedata_q <= data_q[idx];
          end else if (state_d == MEM_FETCH) begin
            mem_read_q    <= 1'b1;
            mem_address_q <= ADDRESS[7:OFF_W];
          end
        end
        WRITE_BACK: begin
          if (state_d == MEM_FETCH) begin
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_address_q <= ADDRESS[7:OFF_W];
          end
        end
        MEM_FETCH: begin
          if (state_d == UPDATE) begin
            mem_read_q <= 1'b0;
            fill_q     <= MEM_READDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == UPDATE) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; cleared valid bits make their contents unobservable.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state_q == UPDATE) begin
        tag_q[idx]  <= addr_tag;
        data_q[idx] <= fill_q;
      end else if (write_hit) begin
        data_q[idx][{offset, 3'b000} +: 8] <= WRITEDATA;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if ((state_q == IDLE) && req && hit && (hit_count_q != 16'hFFFF))
        hit_count_q <= hit_count_q + 16'd1;
      if ((state_q == IDLE) && (state_d != IDLE) && (miss_count_q != 16'hFFFF))
        miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule
